double_frame_buffer: RTL and testbench
======================================

// Module: double_frame_buffer
// PURPOSE
//  Pixel source directly upstream of the VGA video driver. Holds two WIDTHxHEIGHT RGB332 frame buffers
//  (front/back). Answers the driver's x/y requests with expanded 8-bit r/g/b read from the front buffer.
//  Accepts pixel writes and a hardware fill ("clear") into the back buffer. Swaps buffers only at a frame
//  boundary, so the display is tear-free.
// PARAMETERS
//  WIDTH   160  logical pixels per line; must match the video driver WIDTH
//  HEIGHT  120  logical lines per frame; must match the video driver HEIGHT
// PORTS
//  clk           in   1   system clock, same clock as the video driver
//  reset         in   1   synchronous, active-high
//  x             in   10  requested pixel column, from the video driver
//  y             in   9   requested pixel row, from the video driver
//  r, g, b       out  8   pixel colour to the video driver, one output each
//  wr_en         in   1   pixel write strobe; accepted when wr_en & wr_ready
//  wr_x          in   10  write column
//  wr_y          in   9   write row
//  wr_color      in   8   RGB332 pixel value, {R[2:0],G[2:0],B[1:0]}
//  wr_ready      out  1   write interface can accept
//  clr_start     in   1   one-cycle pulse: fill the back buffer with clr_color
//  clr_color     in   8   RGB332 fill value, sampled in the clr_start cycle
//  clr_busy      out  1   fill in progress
//  swap_req      in   1   one-cycle pulse: request a front/back exchange
//  swap_pending  out  1   swap requested, not yet performed
//  front_sel     out  1   index of the buffer currently displayed
// BEHAVIOUR
//  Reset values:
//   - r = g = b = 0, front_sel = 0, swap_pending = 0, clr_busy = 0, wr_ready = 1.
//   - RAM contents are not reset.
//   - Reset during a fill aborts the fill immediately.
//  Addressing: addr = y*WIDTH + x. Buffer n occupies words n*WIDTH*HEIGHT .. (n+1)*WIDTH*HEIGHT-1.
//  Read path:
//   - 1-cycle latency: r/g/b at edge k+1 reflect x/y sampled at edge k.
//   - If x >= WIDTH or y >= HEIGHT, output 0 (black).
//   - Expansion: r = {c[7:5],c[7:5],c[7:6]}, g = {c[4:2],c[4:2],c[4:3]}, b = {c[1:0] repeated 4 times}.
//  Write path:
//   - Accepted writes go to the back buffer (~front_sel) at the next edge.
//   - Writes with wr_x >= WIDTH or wr_y >= HEIGHT are silently dropped.
//   - wr_ready = ~clr_busy. Writes presented while wr_ready = 0 are ignored, not queued.
//  Fill FSM, states IDLE and FILL:
//   - IDLE -> FILL on clr_start. Latches clr_color and the back-buffer index; address counter = 0.
//   - FILL writes one word per cycle, counter 0 .. WIDTH*HEIGHT-1, then returns to IDLE.
//   - clr_busy = 1 for exactly WIDTH*HEIGHT cycles, starting the cycle after clr_start.
//   - clr_start while busy is ignored.
//   - A write and clr_start in the same cycle: the write is performed, then the fill overwrites it.
//  Frame boundary: a cycle in which registered y_prev != 0 and y == 0, i.e. end of the active frame.
//  Swap:
//   - swap_req sets swap_pending.
//   - At a frame boundary with swap_pending = 1 and clr_busy = 0: toggle front_sel, clear swap_pending.
//   - swap_req while already pending: no extra effect.
//   - swap_req in the same cycle as a boundary: swap waits for the next boundary.
//   - Boundary while clr_busy = 1: swap deferred to the next boundary after the fill completes.
//  Memory: one true-dual-port RAM of 2*WIDTH*HEIGHT x 8 (38400 bytes at defaults), block RAM inferred.
//   - Port A: read. Port B: write/fill. No read/write collision, since front and back never coincide.
//  No combinational path from any input to r/g/b.
// TESTING
//  1. Reset, then write (3,2) = 8'hE0 and swap_req; drive y 5 -> 0; then drive x=3, y=2
//     -> front_sel = 1 after the boundary; next cycle r = 8'hFF, g = 0, b = 0.
//  2. clr_start with clr_color = 8'h1C -> clr_busy high for 19200 cycles; wr_ready = 0 throughout.
//     Then swap and read (0,0) and (159,119) -> g = 8'hFF at both, r = b = 0.
//  3. swap_req mid-fill, boundary occurs while busy -> front_sel unchanged, swap_pending = 1.
//     The first boundary after clr_busy falls -> front_sel toggles, swap_pending = 0.
//  4. Write to (160,0) and (0,120) -> no RAM change; read x = 200 -> r = g = b = 0.
//  5. swap_req in the same cycle as a boundary -> no toggle then; toggle at the following boundary.
//  6. Assert reset 100 cycles into a fill -> clr_busy = 0, wr_ready = 1, front_sel = 0 next edge.
//     Fresh clr_start then runs the full 19200 cycles.

Source files
------------

// File: rtl/double_frame_buffer.sv
// rtl/double_frame_buffer.sv - tear-free RGB332 front/back frame store feeding the VGA driver
module double_frame_buffer #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [8:0] y,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  input  logic       wr_en,
  input  logic [9:0] wr_x,
  input  logic [8:0] wr_y,
  input  logic [7:0] wr_color,
  output logic       wr_ready,
  input  logic       clr_start,
  input  logic [7:0] clr_color,
  output logic       clr_busy,
  input  logic       swap_req,
  output logic       swap_pending,
  output logic       front_sel
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int AW = $clog2(2 * N);

  typedef enum logic {IDLE, FILL} state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   fill_cnt;
  logic [7:0]      fill_color;
  logic            fill_buf;
  logic [7:0]      mem [0:2*N-1];
  logic [7:0]      rd_data;
  logic            rd_valid;
  logic [8:0]      y_prev;
  logic            boundary;
  logic            rd_in, wr_in;
  logic            we;
  logic [AW-1:0]   wa, rd_addr;
  logic [7:0]      wd;

  function automatic logic [AW-1:0] buf_addr(input logic sel, input logic [9:0] px,
                                             input logic [8:0] py);
    return (sel ? AW'(N) : '0) + AW'(py) * AW'(WIDTH) + AW'(px);
  endfunction

  assign rd_in    = (x < 10'(WIDTH)) && (y < 9'(HEIGHT));
  assign wr_in    = (wr_x < 10'(WIDTH)) && (wr_y < 9'(HEIGHT));
  assign rd_addr  = buf_addr(front_sel, x, y);
  assign clr_busy = (state == FILL);
  assign wr_ready = ~clr_busy;
  assign boundary = (y_prev != 9'd0) && (y == 9'd0);

  // Port A: display read; out-of-range pixels are blanked through rd_valid
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) rd_valid <= 1'b0;
    else       rd_valid <= rd_in;
  end

  always_comb begin
    r = 8'd0;
    g = 8'd0;
    b = 8'd0;
    if (rd_valid) begin
      r = {rd_data[7:5], rd_data[7:5], rd_data[7:6]};
      g = {rd_data[4:2], rd_data[4:2], rd_data[4:3]};
      b = {4{rd_data[1:0]}};
    end
  end

  // Port B: fill owns the port while busy, since wr_ready is low then
  always_comb begin
    we = 1'b0;
    wa = buf_addr(~front_sel, wr_x, wr_y);
    wd = wr_color;
    if (!reset) begin
      if (state == FILL) begin
        we = 1'b1;
        wa = (fill_buf ? AW'(N) : '0) + fill_cnt;
        wd = fill_color;
      end else if (wr_en && wr_in) begin
        we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (clr_start) state_nx = FILL;
      FILL: if (fill_cnt == AW'(N - 1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && clr_start) begin
      fill_cnt   <= '0;
      fill_color <= clr_color;
      fill_buf   <= ~front_sel;
    end else if (state == FILL) begin
      fill_cnt <= fill_cnt + 1'b1;
    end
  end

  // Swap only at end of frame, never while a fill is still writing the back buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      y_prev       <= 9'd0;
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
    end else begin
      y_prev <= y;
      if (boundary && swap_pending && state == IDLE) begin
        front_sel    <= ~front_sel;
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_double_frame_buffer.sv
// tb/tb_double_frame_buffer.sv - directed scoreboard bench for double_frame_buffer
module tb_double_frame_buffer;
  localparam int W = 160;
  localparam int H = 120;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] x;
  logic [8:0] y;
  logic [7:0] r, g, b;
  logic       wr_en;
  logic [9:0] wr_x;
  logic [8:0] wr_y;
  logic [7:0] wr_color;
  logic       wr_ready;
  logic       clr_start;
  logic [7:0] clr_color;
  logic       clr_busy;
  logic       swap_req;
  logic       swap_pending;
  logic       front_sel;

  logic [7:0]  mdl [0:2*N-1];
  logic [23:0] sb_q [$];
  logic        fs_exp;
  int          checks = 0;
  int          errors = 0;
  int          busy_cycles;

  always #5 clk = ~clk;

  double_frame_buffer #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .r(r), .g(g), .b(b),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color), .wr_ready(wr_ready),
    .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy),
    .swap_req(swap_req), .swap_pending(swap_pending), .front_sel(front_sel)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [23:0] expand(input logic [7:0] c);
    return {c[7:5], c[7:5], c[7:6], c[4:2], c[4:2], c[4:3], {4{c[1:0]}}};
  endfunction

  task automatic rd(input int px, input int py, input string tag);
    logic [23:0] e;
    if (px < W && py < H) e = expand(mdl[(fs_exp ? N : 0) + py * W + px]);
    else                  e = 24'd0;
    x = 10'(px);
    y = 9'(py);
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    check(tag, {8'd0, r, g, b}, {8'd0, e});
  endtask

  task automatic wr(input int px, input int py, input logic [7:0] c);
    wr_en = 1'b1; wr_x = 10'(px); wr_y = 9'(py); wr_color = c;
    @(negedge clk);
    wr_en = 1'b0;
    if (px < W && py < H) mdl[(fs_exp ? 0 : N) + py * W + px] = c;
  endtask

  task automatic frame();
    y = 9'd5;
    @(negedge clk);
    y = 9'd0;
    @(negedge clk);
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
  endtask

  task automatic model_fill(input logic sel, input logic [7:0] c);
    for (int i = 0; i < N; i++) mdl[(sel ? N : 0) + i] = c;
  endtask

  // Counts busy cycles; with mid set, also exercises swap/write during the fill
  task automatic busy_count(input bit mid, output int cnt);
    int guard;
    int bad_ready;
    cnt = 0; guard = 0; bad_ready = 0;
    while (clr_busy === 1'b1 && guard < 20000) begin
      cnt++;
      if (wr_ready !== 1'b0) bad_ready++;
      if (mid) begin
        if (cnt == 10) swap_req = 1'b1;
        if (cnt == 11) begin swap_req = 1'b0; y = 9'd5; end
        if (cnt == 12) y = 9'd0;
        if (cnt == 14) begin
          check("midfill_front_sel", {31'd0, front_sel}, 32'd0);
          check("midfill_pending", {31'd0, swap_pending}, 32'd1);
        end
        if (cnt == 20) begin wr_en = 1'b1; wr_x = 10'd10; wr_y = 9'd10; wr_color = 8'hE0; end
        if (cnt == 21) wr_en = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    check("wr_ready_low_while_busy", 32'(bad_ready), 32'd0);
  endtask

  initial begin
    reset = 1'b1; x = '0; y = '0; wr_en = 1'b0; wr_x = '0; wr_y = '0; wr_color = '0;
    clr_start = 1'b0; clr_color = '0; swap_req = 1'b0; fs_exp = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rgb", {8'd0, r, g, b}, 32'd0);
    check("reset_front_sel", {31'd0, front_sel}, 32'd0);
    check("reset_pending", {31'd0, swap_pending}, 32'd0);
    check("reset_busy", {31'd0, clr_busy}, 32'd0);
    check("reset_wr_ready", {31'd0, wr_ready}, 32'd1);
    reset = 1'b0;
    @(negedge clk);

    // basic write, swap at boundary, red pixel
    wr(3, 2, 8'hE0);
    wr(0, 0, 8'h03);
    pulse_swap();
    check("swap_pending_set", {31'd0, swap_pending}, 32'd1);
    frame();
    fs_exp = 1'b1;
    check("t1_front_sel", {31'd0, front_sel}, 32'd1);
    check("t1_pending_clr", {31'd0, swap_pending}, 32'd0);
    rd(3, 2, "t1_red_pixel");
    check("t1_red_const", {8'd0, r, g, b}, 32'hFF0000);

    // out-of-range writes/reads
    wr(0, 1, 8'h02);
    wr(160, 0, 8'hE0);
    wr(0, 120, 8'hE0);
    rd(0, 0, "t4_front_untouched");
    rd(200, 0, "t4_x_out_black");
    check("t4_black_const", {8'd0, r, g, b}, 32'd0);

    // swap_req coincident with a boundary waits for the next one
    y = 9'd5;
    @(negedge clk);
    y = 9'd0; swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    check("t5_no_toggle", {31'd0, front_sel}, 32'd1);
    check("t5_still_pending", {31'd0, swap_pending}, 32'd1);
    frame();
    fs_exp = 1'b0;
    check("t5_toggle_next", {31'd0, front_sel}, 32'd0);
    rd(0, 1, "t4_drop_x_wrap");

    // fill with concurrent write, swap deferred while busy
    clr_start = 1'b1; clr_color = 8'h1C;
    wr_en = 1'b1; wr_x = 10'd5; wr_y = 9'd5; wr_color = 8'hFF;
    @(negedge clk);
    clr_start = 1'b0; wr_en = 1'b0;
    busy_count(1'b1, busy_cycles);
    check("t2_busy_cycles", 32'(busy_cycles), 32'(N));
    model_fill(1'b1, 8'h1C);
    check("t3_front_after_fill", {31'd0, front_sel}, 32'd0);
    check("t3_pending_after_fill", {31'd0, swap_pending}, 32'd1);
    frame();
    fs_exp = 1'b1;
    check("t3_toggle", {31'd0, front_sel}, 32'd1);
    check("t3_pending_clr", {31'd0, swap_pending}, 32'd0);
    rd(0, 0, "t2_first");
    rd(159, 119, "t2_last");
    check("t2_green_const", {8'd0, r, g, b}, 32'h00FF00);
    rd(5, 5, "t2_fill_over_write");
    rd(10, 10, "t2_write_while_busy");

    // reset aborts a fill
    clr_start = 1'b1; clr_color = 8'hE0;
    @(negedge clk);
    clr_start = 1'b0;
    repeat (100) @(negedge clk);
    check("t6_busy_before_reset", {31'd0, clr_busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    fs_exp = 1'b0;
    check("t6_busy_clr", {31'd0, clr_busy}, 32'd0);
    check("t6_wr_ready", {31'd0, wr_ready}, 32'd1);
    check("t6_front_sel", {31'd0, front_sel}, 32'd0);
    check("t6_rgb", {8'd0, r, g, b}, 32'd0);
    clr_start = 1'b1; clr_color = 8'h03;
    @(negedge clk);
    clr_start = 1'b0;
    busy_count(1'b0, busy_cycles);
    check("t6_full_fill", 32'(busy_cycles), 32'(N));
    model_fill(1'b1, 8'h03);
    pulse_swap();
    frame();
    fs_exp = 1'b1;
    check("t6_swap", {31'd0, front_sel}, 32'd1);
    rd(0, 0, "t6_first");
    rd(159, 119, "t6_last");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
